// File: rtl/fb_write_arbiter_pkg.sv
// Shared definitions for the framebuffer write-port arbiter.
//   fb_depth / fb_addr_w : derive RAM depth and address width from the panel geometry
//   fill_state_t         : fill engine FSM states
//   grant_t              : which requester owns RAM port A in a given cycle
package fb_pkg;

  typedef enum logic [1:0] {
    FILL_IDLE,
    FILL_RUN,
    FILL_DONE
  } fill_state_t;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_CTRL,
    GNT_DBG,
    GNT_FILL
  } grant_t;

  function automatic int fb_depth(input int width, input int height, input int bpp);
    return width * height * bpp;
  endfunction

  function automatic int fb_addr_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/fb_write_arbiter_if.sv
// RAM-side bus of framebuffer write port A (multimem AddressA/DataInA/WrA/ClockEnA).
//   master : driven by the arbiter
//   slave  : observed by the RAM (or a bench)
interface fb_write_arbiter_if #(
  parameter int ADDR_W = 12
);
  logic [ADDR_W-1:0] ram_address;
  logic [7:0]        ram_data_out;
  logic              ram_write_enable;
  logic              ram_clk_enable;

  modport master (
    output ram_address,
    output ram_data_out,
    output ram_write_enable,
    output ram_clk_enable
  );

  modport slave (
    input ram_address,
    input ram_data_out,
    input ram_write_enable,
    input ram_clk_enable
  );
endinterface

// File: rtl/fb_fill_engine.sv
// Fill engine: paints every framebuffer byte with a latched RGB565 colour.
//   fill_start/fill_abort/fill_pattern : control from the host
//   fill_gnt                           : arbiter accepted this cycle's fill write
//   fill_req/fill_addr/fill_data       : write request toward the arbiter
//   fill_busy/fill_done                : registered status
//
// state     | meaning
// FILL_IDLE | waiting for fill_start
// FILL_RUN  | requesting a write at ptr each cycle, ptr advances only when granted
// FILL_DONE | one-cycle fill_done pulse, then back to idle
module fb_fill_engine
  import fb_pkg::*;
#(
  parameter int DEPTH  = 4096,
  parameter int ADDR_W = 12
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic              fill_start,
  input  logic              fill_abort,
  input  logic [15:0]       fill_pattern,
  input  logic              fill_gnt,
  output logic              fill_req,
  output logic [ADDR_W-1:0] fill_addr,
  output logic [7:0]        fill_data,
  output logic              fill_busy,
  output logic              fill_done
);

  localparam logic [ADDR_W:0] LAST_PTR = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] PTR_ONE  = (ADDR_W+1)'(1);

  fill_state_t     state;
  logic [ADDR_W:0] ptr;
  logic [15:0]     pattern;

  // An abort masks the request so the abort cycle issues no write.
  assign fill_req  = (state == FILL_RUN) && !fill_abort;
  assign fill_addr = ptr[ADDR_W-1:0];
  // RGB565 is stored big-endian: high byte at the even address.
  assign fill_data = ptr[0] ? pattern[7:0] : pattern[15:8];

  always_ff @(posedge clk_in) begin
    if (!reset) begin
      state     <= FILL_IDLE;
      ptr       <= '0;
      pattern   <= '0;
      fill_busy <= 1'b0;
      fill_done <= 1'b0;
    end else begin
      fill_done <= 1'b0;
      case (state)
        FILL_IDLE: begin
          if (fill_start && !fill_abort) begin
            pattern   <= fill_pattern;
            ptr       <= '0;
            fill_busy <= 1'b1;
            state     <= FILL_RUN;
          end
        end
        FILL_RUN: begin
          if (fill_abort) begin
            fill_busy <= 1'b0;
            ptr       <= '0;
            state     <= FILL_IDLE;
          end else if (fill_gnt) begin
            ptr <= ptr + PTR_ONE;
            if (ptr == LAST_PTR) begin
              fill_busy <= 1'b0;
              fill_done <= 1'b1;
              state     <= FILL_DONE;
            end
          end
        end
        FILL_DONE: state <= FILL_IDLE;
        default:   state <= FILL_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/fb_write_arbiter.sv
// Framebuffer write port A arbiter: shares multimem port A between the
// control_module byte stream, debugger byte writes and the fill engine.
//   clk_in, reset (sync, active-low)
//   ctrl_*  : control_module port, highest priority, never stalled
//   dbg_*   : debugger valid/ready write port, dbg_drop flags out-of-range writes
//   fill_*  : fill engine control and status
//   ram     : registered RAM-side bus (master modport)
module fb_write_arbiter
  import fb_pkg::*;
#(
  parameter int PIXEL_WIDTH     = 64,
  parameter int PIXEL_HEIGHT    = 32,
  parameter int BYTES_PER_PIXEL = 2,
  localparam int DEPTH  = fb_depth(PIXEL_WIDTH, PIXEL_HEIGHT, BYTES_PER_PIXEL),
  localparam int ADDR_W = fb_addr_w(DEPTH)
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic [ADDR_W-1:0] ctrl_address,
  input  logic [7:0]        ctrl_data,
  input  logic              ctrl_we,
  input  logic              ctrl_clk_enable,
  input  logic              dbg_valid,
  input  logic [ADDR_W:0]   dbg_address,
  input  logic [7:0]        dbg_data,
  output logic              dbg_ready,
  output logic              dbg_drop,
  input  logic              fill_start,
  input  logic              fill_abort,
  input  logic [15:0]       fill_pattern,
  output logic              fill_busy,
  output logic              fill_done,
  fb_write_arbiter_if.master ram
);

  localparam logic [ADDR_W:0] DBG_LIMIT = (ADDR_W+1)'(DEPTH);

  grant_t            grant;
  logic              fill_req;
  logic              fill_gnt;
  logic [ADDR_W-1:0] fill_addr;
  logic [7:0]        fill_data;

  // Any ctrl access (read or write) occupies the port.
  assign dbg_ready = reset && !ctrl_clk_enable;
  assign fill_gnt  = (grant == GNT_FILL);

  always_comb begin
    grant = GNT_NONE;
    if (ctrl_clk_enable)
      grant = GNT_CTRL;
    else if (dbg_valid)
      grant = GNT_DBG;
    else if (fill_req)
      grant = GNT_FILL;
  end

  fb_fill_engine #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fill (
    .clk_in       (clk_in),
    .reset        (reset),
    .fill_start   (fill_start),
    .fill_abort   (fill_abort),
    .fill_pattern (fill_pattern),
    .fill_gnt     (fill_gnt),
    .fill_req     (fill_req),
    .fill_addr    (fill_addr),
    .fill_data    (fill_data),
    .fill_busy    (fill_busy),
    .fill_done    (fill_done)
  );

  // Idle cycles leave address/data at their last values; only the enables drop.
  always_ff @(posedge clk_in) begin
    if (!reset) begin
      ram.ram_address      <= '0;
      ram.ram_data_out     <= '0;
      ram.ram_write_enable <= 1'b0;
      ram.ram_clk_enable   <= 1'b0;
      dbg_drop             <= 1'b0;
    end else begin
      ram.ram_write_enable <= 1'b0;
      ram.ram_clk_enable   <= 1'b0;
      dbg_drop             <= 1'b0;
      case (grant)
        GNT_CTRL: begin
          ram.ram_address      <= ctrl_address;
          ram.ram_data_out     <= ctrl_data;
          ram.ram_write_enable <= ctrl_we;
          ram.ram_clk_enable   <= 1'b1;
        end
        GNT_DBG: begin
          if (dbg_address >= DBG_LIMIT) begin
            dbg_drop <= 1'b1;
          end else begin
            ram.ram_address      <= dbg_address[ADDR_W-1:0];
            ram.ram_data_out     <= dbg_data;
            ram.ram_write_enable <= 1'b1;
            ram.ram_clk_enable   <= 1'b1;
          end
        end
        GNT_FILL: begin
          ram.ram_address      <= fill_addr;
          ram.ram_data_out     <= fill_data;
          ram.ram_write_enable <= 1'b1;
          ram.ram_clk_enable   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Directed bench for fb_write_arbiter.
module tb_fb_write_arbiter;

  logic        clk_in;
  logic        reset;
  logic [11:0] ctrl_address;
  logic [7:0]  ctrl_data;
  logic        ctrl_we;
  logic        ctrl_clk_enable;
  logic        dbg_valid;
  logic [12:0] dbg_address;
  logic [7:0]  dbg_data;
  logic        dbg_ready;
  logic        dbg_drop;
  logic        fill_start;
  logic        fill_abort;
  logic [15:0] fill_pattern;
  logic        fill_busy;
  logic        fill_done;

  int total = 0;
  int bad   = 0;

  fb_write_arbiter_if #(.ADDR_W(12)) rif ();

  fb_write_arbiter dut (
    .clk_in          (clk_in),
    .reset           (reset),
    .ctrl_address    (ctrl_address),
    .ctrl_data       (ctrl_data),
    .ctrl_we         (ctrl_we),
    .ctrl_clk_enable (ctrl_clk_enable),
    .dbg_valid       (dbg_valid),
    .dbg_address     (dbg_address),
    .dbg_data        (dbg_data),
    .dbg_ready       (dbg_ready),
    .dbg_drop        (dbg_drop),
    .fill_start      (fill_start),
    .fill_abort      (fill_abort),
    .fill_pattern    (fill_pattern),
    .fill_busy       (fill_busy),
    .fill_done       (fill_done),
    .ram             (rif)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    ctrl_address    = '0;
    ctrl_data       = '0;
    ctrl_we         = 1'b0;
    ctrl_clk_enable = 1'b0;
    dbg_valid       = 1'b0;
    dbg_address     = '0;
    dbg_data        = '0;
    fill_start      = 1'b0;
    fill_abort      = 1'b0;
    fill_pattern    = '0;
  endtask

  logic        e_ce, e_we, e_drop, e_done;
  logic [11:0] e_addr;
  logic [7:0]  e_data;
  int          exp_ptr;
  int          drops;
  logic        done_seen;

  initial begin
    reset = 1'b0;
    clear_inputs();

    // reset with busy random inputs
    for (int i = 0; i < 3; i++) begin
      ctrl_address    = 12'($urandom);
      ctrl_data       = 8'($urandom);
      ctrl_we         = 1'b1;
      ctrl_clk_enable = 1'b1;
      dbg_valid       = 1'b1;
      dbg_address     = 13'($urandom);
      dbg_data        = 8'($urandom);
      fill_start      = 1'b1;
      fill_pattern    = 16'($urandom);
      tick();
      check("rst_ram", {rif.ram_address, rif.ram_data_out, rif.ram_write_enable, rif.ram_clk_enable}, 32'h0);
      check("rst_status", {dbg_ready, dbg_drop, fill_busy, fill_done}, 4'b0000);
    end
    clear_inputs();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("idle_ce", rif.ram_clk_enable, 1'b0);
    end
    check("idle_busy", fill_busy, 1'b0);

    // ctrl write
    ctrl_address = 12'h005; ctrl_data = 8'hA5; ctrl_we = 1'b1; ctrl_clk_enable = 1'b1;
    #1;
    check("ctrl_dbg_ready", dbg_ready, 1'b0);
    tick();
    clear_inputs();
    check("ctrl_wr", {rif.ram_address, rif.ram_data_out, rif.ram_write_enable, rif.ram_clk_enable}, {12'h005, 8'hA5, 2'b11});
    tick();
    check("ctrl_idle", {rif.ram_address, rif.ram_write_enable, rif.ram_clk_enable}, {12'h005, 2'b00});

    // ctrl read
    ctrl_address = 12'h123; ctrl_data = 8'h00; ctrl_we = 1'b0; ctrl_clk_enable = 1'b1;
    tick();
    clear_inputs();
    check("ctrl_rd", {rif.ram_address, rif.ram_write_enable, rif.ram_clk_enable}, {12'h123, 2'b01});

    // dbg contending with ctrl
    dbg_valid = 1'b1; dbg_address = 13'h010; dbg_data = 8'h3C;
    ctrl_address = 12'h020; ctrl_data = 8'h77; ctrl_we = 1'b1; ctrl_clk_enable = 1'b1;
    #1;
    check("contend_ready0", dbg_ready, 1'b0);
    tick();
    check("contend_ctrl", {rif.ram_address, rif.ram_data_out, rif.ram_write_enable, rif.ram_clk_enable}, {12'h020, 8'h77, 2'b11});
    ctrl_we = 1'b0; ctrl_clk_enable = 1'b0;
    #1;
    check("contend_ready1", dbg_ready, 1'b1);
    tick();
    clear_inputs();
    check("contend_dbg", {rif.ram_address, rif.ram_data_out, rif.ram_write_enable, rif.ram_clk_enable}, {12'h010, 8'h3C, 2'b11});
    check("contend_nodrop", dbg_drop, 1'b0);
    tick();
    check("contend_idle", rif.ram_clk_enable, 1'b0);

    // uncontended fill
    fill_start = 1'b1; fill_pattern = 16'h1234;
    tick();
    clear_inputs();
    check("fill_busy_start", fill_busy, 1'b1);
    for (int i = 0; i < 4096; i++) begin
      tick();
      check("fill_wr", {rif.ram_address, rif.ram_data_out, rif.ram_write_enable, rif.ram_clk_enable},
            {12'(i), ((i % 2) == 0) ? 8'h12 : 8'h34, 2'b11});
      check("fill_status", {fill_busy, fill_done}, {(i != 4095), (i == 4095)});
    end
    tick();
    check("fill_after", {fill_busy, fill_done, rif.ram_clk_enable}, 3'b000);

    // fill with ctrl every 4th cycle and one out-of-range dbg write
    fill_start = 1'b1; fill_pattern = 16'hABCD;
    tick();
    clear_inputs();
    exp_ptr = 0; drops = 0; done_seen = 1'b0;
    for (int cyc = 0; cyc < 6000 && !done_seen; cyc++) begin
      ctrl_clk_enable = ((cyc % 4) == 3);
      ctrl_we         = ((cyc % 4) == 3);
      ctrl_address    = 12'(cyc);
      ctrl_data       = 8'(cyc + 1);
      dbg_valid       = (cyc == 10);
      dbg_address     = 13'h1000;
      dbg_data        = 8'hEE;
      e_ce = 1'b0; e_we = 1'b0; e_addr = '0; e_data = '0; e_drop = 1'b0; e_done = 1'b0;
      if (ctrl_clk_enable) begin
        e_ce = 1'b1; e_we = 1'b1; e_addr = ctrl_address; e_data = ctrl_data;
      end else if (dbg_valid) begin
        e_drop = 1'b1;
      end else if (exp_ptr < 4096) begin
        e_ce = 1'b1; e_we = 1'b1; e_addr = 12'(exp_ptr);
        e_data = ((exp_ptr % 2) == 0) ? 8'hAB : 8'hCD;
        exp_ptr++;
        e_done = (exp_ptr == 4096);
      end
      if (cyc == 10) begin
        #1;
        check("mix_dbg_ready", dbg_ready, 1'b1);
      end
      tick();
      check("mix_en", {rif.ram_write_enable, rif.ram_clk_enable}, {e_we, e_ce});
      if (e_ce)
        check("mix_wr", {rif.ram_address, rif.ram_data_out}, {e_addr, e_data});
      check("mix_drop", dbg_drop, e_drop);
      check("mix_done", fill_done, e_done);
      if (dbg_drop) drops++;
      done_seen = fill_done;
    end
    clear_inputs();
    check("mix_finished", done_seen, 1'b1);
    check("mix_ptr", exp_ptr, 4096);
    check("mix_drops", drops, 1);
    tick();
    check("mix_after", {fill_busy, fill_done, dbg_drop}, 3'b000);

    // abort at pointer 0x800, with an ignored fill_start mid-run
    fill_start = 1'b1; fill_pattern = 16'h00FF;
    tick();
    clear_inputs();
    check("abort_busy", fill_busy, 1'b1);
    for (int i = 0; i < 2048; i++) begin
      if (i == 100) begin
        fill_start = 1'b1; fill_pattern = 16'hFFFF;
      end else begin
        fill_start = 1'b0;
      end
      tick();
      check("abort_run", {rif.ram_address, rif.ram_data_out, rif.ram_clk_enable},
            {12'(i), ((i % 2) == 0) ? 8'h00 : 8'hFF, 1'b1});
    end
    fill_start = 1'b0;
    fill_abort = 1'b1;
    tick();
    fill_abort = 1'b0;
    check("abort_cut", {fill_busy, fill_done, rif.ram_clk_enable}, 3'b000);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("abort_quiet", {fill_busy, fill_done, rif.ram_clk_enable}, 3'b000);
    end

    // reset at pointer 0x800
    fill_start = 1'b1; fill_pattern = 16'h5555;
    tick();
    clear_inputs();
    for (int i = 0; i < 2048; i++) tick();
    check("rrun_last", {rif.ram_address, fill_busy}, {12'h7FF, 1'b1});
    reset = 1'b0;
    tick();
    check("rrun_rst", {rif.ram_address, rif.ram_data_out, rif.ram_write_enable, rif.ram_clk_enable,
                       fill_busy, fill_done}, 32'h0);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("rrun_quiet", {fill_busy, fill_done, rif.ram_clk_enable}, 3'b000);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
